// File: rtl/bus_transaction_unit.sv
// Turns controller transaction codes into single handshaked memory-bus cycles,
// with lane steering, read capture, back-to-back issue and a hung-bus timeout.
module bus_transaction_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  txnOp,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        stall,
  output logic        memReq,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [3:0]  memByteEnable,
  output logic [31:0] memWriteData,
  input  logic        memAck,
  input  logic [31:0] memReadData,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        busError
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state, state_next;
  logic [CW-1:0] counter;
  logic          opValid, opWrite, accept, timeout, readDone;
  logic [3:0]    opBe;
  logic [31:0]   opData;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^address[1:0];

  always_comb begin
    opValid = 1'b1;
    opWrite = 1'b1;
    opBe    = '0;
    opData  = writeData;
    case (txnOp)
      4'd1: begin opWrite = 1'b0; opBe = 4'b1111; end
      4'd2: begin opBe = 4'b0001; opData = {4{writeData[7:0]}}; end
      4'd3: begin opBe = 4'b0010; opData = {4{writeData[7:0]}}; end
      4'd4: begin opBe = 4'b0100; opData = {4{writeData[7:0]}}; end
      4'd5: begin opBe = 4'b1000; opData = {4{writeData[7:0]}}; end
      4'd6: begin opBe = 4'b0011; opData = {2{writeData[15:0]}}; end
      4'd7: begin opBe = 4'b1100; opData = {2{writeData[15:0]}}; end
      4'd8: opBe = 4'b1111;
      default: begin opValid = 1'b0; opWrite = 1'b0; end
    endcase
  end

  // A new op may only be taken while the bus is free or completing this cycle.
  always_comb begin
    accept     = opValid && ((state == IDLE) || memAck);
    timeout    = (state == BUS) && !memAck && (counter == COUNT_MAX);
    readDone   = (state == BUS) && memAck && !memWrite;
    state_next = state;
    if (accept)
      state_next = BUS;
    else if ((state == BUS) && (memAck || timeout))
      state_next = IDLE;
  end

  assign stall  = (state == BUS) && !memAck;
  assign memReq = (state == BUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      memWrite      <= 1'b0;
      memAddress    <= '0;
      memByteEnable <= '0;
      memWriteData  <= '0;
      readData      <= '0;
      readValid     <= 1'b0;
      busError      <= 1'b0;
    end else begin
      state     <= state_next;
      readValid <= readDone;
      busError  <= timeout;
      if (readDone)
        readData <= memReadData;
      if (accept) begin
        counter       <= '0;
        memWrite      <= opWrite;
        memAddress    <= {address[31:2], 2'b00};
        memByteEnable <= opBe;
        memWriteData  <= opData;
      end else if ((state == BUS) && !memAck) begin
        counter <= counter + 1'b1;
      end
    end
  end

endmodule

// File: doc/bus_transaction_unit.md
Name: bus_transaction_unit

Overview:
Sits directly downstream of the controller's registered transaction-control output and turns each transaction code into one handshaked memory-bus cycle. It generates byte enables and lane-replicated write data, captures read data, and drives a stall back to the controller. The controller feeds `~stall` into its enable. A per-transaction timeout counter flags a hung bus.

Parameters:
TIMEOUT_CYCLES, 256, BUS cycles without ack before abort. Legal range 2..65535; counter width is clog2(TIMEOUT_CYCLES).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
txnOp  input  4  transaction code: 0 NO_OP, 1 READ, 2-5 WRITE_BYTE0-3, 6 WRITE_WORD0, 7 WRITE_WORD1, 8 WRITE_DWORD; 9-15 treated as NO_OP
address  input  32  byte address, sampled on accept
writeData  input  32  store data; byte in [7:0], word in [15:0]
stall  output  1  controller must hold its state/registers
memReq  output  1  bus request
memWrite  output  1  1 = write, 0 = read
memAddress  output  32  {address[31:2],2'b00}
memByteEnable  output  4  active lanes
memWriteData  output  32  lane-replicated data
memAck  input  1  one-cycle completion, sampled while memReq=1
memReadData  input  32  valid when memAck=1 on a read
readData  output  32  captured read data
readValid  output  1  one-cycle pulse, readData updated
busError  output  1  one-cycle pulse on timeout

Behaviour:
- Reset values: all outputs 0. State is IDLE and the counter is 0. Asserting reset mid-transaction drops memReq immediately (asynchronous), with no readValid or busError pulse.
- FSM states: IDLE and BUS.
- Accept condition: txnOp is a valid non-NO_OP code, AND either the state is IDLE or the state is BUS with memAck=1.
- On accept, at the clock edge: latch op, address and writeData into the output registers; clear the counter; state becomes BUS.
- stall = (state==BUS) && !memAck. stall is combinational and is 0 in IDLE.
- Because stall is 0 in the accepting cycle, the controller advances in that same cycle, so an op is never issued twice.
- BUS outputs: memReq=1. memAddress, memWrite, memByteEnable and memWriteData are registered and stable until the ack edge.
- Lane encoding:
  - READ: BE 1111, memWrite=0.
  - BYTEn: BE = 1<<n, data = {4{d[7:0]}}.
  - WORD0: BE 0011, data = {2{d[15:0]}}.
  - WORD1: BE 1100, data = {2{d[15:0]}}.
  - DWORD: BE 1111, data = d.
- BUS with memAck=1:
  - If the op was READ: readData <= memReadData and readValid=1 in the next cycle.
  - Then, if accept: back-to-back, stay in BUS with the new op (no idle cycle).
  - Else: go to IDLE with memReq=0 next cycle.
- BUS with memAck=0: counter increments.
  - If counter == TIMEOUT_CYCLES-1: busError pulses next cycle, state goes to IDLE, memReq drops, no readData update. The controller is released.
- Minimum latency: op present cycle 0, memReq cycle 1, ack cycle 1, readValid/readData cycle 2.
- memAck while memReq=0 is ignored.
- readData holds its value between reads.

Test Plan:
- Reset then idle with txnOp=0 -> memReq, stall, readValid, busError all stay 0 for 20 cycles.
- READ at address 0x1003, memAck in the 3rd BUS cycle with memReadData=0xDEADBEEF -> memAddress=0x1000, BE=1111, memWrite=0. stall is 1 for the first two BUS cycles and 0 in the ack cycle. Next cycle readData=0xDEADBEEF and readValid=1 for one cycle.
- WRITE_BYTE2 with writeData=0x000000A5, then WRITE_WORD1 with 0x00001234 -> BE 0100 / data 0xA5A5A5A5, then BE 1100 / data 0x12341234.
- Back-to-back: WRITE_DWORD 0xCAFEF00D acked in its first BUS cycle while txnOp=READ -> memReq stays 1 continuously and the second transaction shows BE 1111, memWrite=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> memReq high for exactly 4 cycles, then busError pulses once, stall=0, state is IDLE.
- Reset asserted on the 2nd BUS cycle of a READ -> memReq falls without waiting for a clock edge, readValid never pulses, and the next READ behaves as from reset.
